// File: rtl/spm_product_collector_pkg.sv
// Shared definitions for the SPM product collector: state encoding and default width.
// No logic; used only for types and constants.
// No flow control.
package spm_product_collector_pkg;

    // Default SPM operand width; the product is twice this wide.
    localparam int SPM_WIDTH = 32;
    localparam int SPM_PW    = 2 * SPM_WIDTH;

    // Collector states: waiting for start, shifting beats in, holding a finished product.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } spm_state_e;

endpackage

// File: rtl/spm_product_collector.sv
// Collects the LSB-first serial SPM product into a parallel register and offers it via valid/ready.
// Latency: prod_valid rises one cycle after the PW-th accepted beat.
// Backpressure: product held in DONE until prod_ready; beats arriving outside COLLECT are dropped and flagged.
module spm_product_collector
    import spm_product_collector_pkg::*;
#(
    parameter int WIDTH = SPM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic [2*WIDTH-1:0]   prod_out,
    output logic                 prod_valid,
    input  logic                 prod_ready,
    output logic                 busy,
    output logic                 overrun
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(PW);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PW - 1);

    spm_state_e        state_q, state_d;
    logic [PW-1:0]     shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [PW-1:0]     prod_q,  prod_d;
    logic              overrun_q, overrun_d;

    // A start in DONE only counts when the held product is being taken the same cycle.
    logic              start_acc;
    logic [PW-1:0]     shreg_shift;

    assign start_acc   = start && ((state_q != S_DONE) || prod_ready);
    assign shreg_shift = {bit_in, shreg_q[PW-1:1]};

    // Next-state for FSM, shift register, beat counter, product register and overrun flag.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        overrun_d = overrun_q;

        if (start_acc) begin
            // Any accepted start (re)arms collection from a clean slate, including abort mid-product.
            state_d   = S_COLLECT;
            shreg_d   = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bit_valid) begin
                        overrun_d = 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (bit_valid) begin
                        shreg_d = shreg_shift;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BEAT) begin
                            prod_d  = shreg_shift;
                            cnt_d   = '0;
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (prod_ready) begin
                        state_d = S_IDLE;
                    end
                    // Beats here are never merged into the held product.
                    if (bit_valid) begin
                        overrun_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift register and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Completed product and sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            prod_q    <= prod_d;
            overrun_q <= overrun_d;
        end
    end

    assign prod_out   = prod_q;
    assign prod_valid = (state_q == S_DONE);
    assign busy       = (state_q == S_COLLECT);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_spm_product_collector.sv
// Bench for spm_product_collector: directed scenarios plus random traffic against a behavioural model.
// Model and DUT are compared on every falling clock edge.
// Inputs change 2 time units after each rising edge.
module tb_spm_product_collector;

    localparam int W  = 32;
    localparam int PW = 2 * W;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          bit_in;
    logic          bit_valid;
    logic [PW-1:0] prod_out;
    logic          prod_valid;
    logic          prod_ready;
    logic          busy;
    logic          overrun;

    int n_checks = 0;
    int n_fail   = 0;

    spm_product_collector #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .prod_out   (prod_out),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic          m_collecting;
    logic          m_pending;
    logic          m_ovr;
    int            m_nbits;
    logic [PW-1:0] m_bits;
    logic [PW-1:0] m_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_collecting <= 1'b0;
            m_pending    <= 1'b0;
            m_ovr        <= 1'b0;
            m_nbits      <= 0;
            m_bits       <= '0;
            m_prod       <= '0;
        end else if (start && (!m_pending || prod_ready)) begin
            m_collecting <= 1'b1;
            m_pending    <= 1'b0;
            m_ovr        <= 1'b0;
            m_nbits      <= 0;
            m_bits       <= '0;
        end else if (m_collecting) begin
            if (bit_valid) begin
                if (m_nbits == PW - 1) begin
                    m_prod       <= m_bits + (bit_in ? (64'd1 << 63) : 64'd0);
                    m_pending    <= 1'b1;
                    m_collecting <= 1'b0;
                    m_nbits      <= 0;
                end else begin
                    m_bits[m_nbits] <= bit_in;
                    m_nbits         <= m_nbits + 1;
                end
            end
        end else begin
            if (m_pending && prod_ready) m_pending <= 1'b0;
            if (bit_valid) m_ovr <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        check("cyc_prod_out",   prod_out,          m_prod);
        check("cyc_prod_valid", PW'(prod_valid),   PW'(m_pending));
        check("cyc_busy",       PW'(busy),         PW'(m_collecting));
        check("cyc_overrun",    PW'(overrun),      PW'(m_ovr));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic s, input logic v, input logic b, input logic r);
        start      = s;
        bit_valid  = v;
        bit_in     = b;
        prod_ready = r;
        cyc();
    endtask

    task automatic idle();
        start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; prod_ready = 1'b0;
    endtask

    task automatic send_word(input logic [PW-1:0] w, input int maxgap, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            int gap;
            gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            repeat (gap) drive(1'b0, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b1, w[i], 1'b0);
        end
        idle();
    endtask

    logic [PW-1:0] held;

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #2;
        check("rst_prod_out",   prod_out,        64'h0);
        check("rst_prod_valid", PW'(prod_valid), 64'h0);
        check("rst_busy",       PW'(busy),       64'h0);
        check("rst_overrun",    PW'(overrun),    64'h0);
        rst_n = 1'b1;
        cyc();

        // 1: 3*5, no gaps
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(64'h0000_0000_0000_000F, 0, PW);
        check("t1_prod",  prod_out,        64'h0000_0000_0000_000F);
        check("t1_valid", PW'(prod_valid), 64'h1);
        check("t1_busy",  PW'(busy),       64'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        cyc();

        // 2: -2*3 with random gaps
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(64'hFFFF_FFFF_FFFF_FFFA, 5, PW);
        check("t2_prod",  prod_out,        64'hFFFF_FFFF_FFFF_FFFA);
        check("t2_valid", PW'(prod_valid), 64'h1);

        // 3: backpressure, then handshake together with start
        repeat (10) drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_hold_prod",  prod_out,        64'hFFFF_FFFF_FFFF_FFFA);
        check("t3_hold_valid", PW'(prod_valid), 64'h1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        idle();
        check("t3_b2b_busy",  PW'(busy),       64'h1);
        check("t3_b2b_valid", PW'(prod_valid), 64'h0);
        send_word(64'h0000_0000_0000_0001, 1, PW);
        check("t3_prod", prod_out, 64'h0000_0000_0000_0001);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        cyc();

        // 4: beat while idle
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        check("t4_overrun", PW'(overrun),    64'h1);
        check("t4_valid",   PW'(prod_valid), 64'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_overrun_clr", PW'(overrun), 64'h0);

        // 5: abort after 20 beats, then full product
        send_word(PW'($urandom) | (PW'($urandom) << 32), 1, 20);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(64'h8000_0000_0000_0000, 2, PW);
        check("t5_prod", prod_out, 64'h8000_0000_0000_0000);
        // beats and a start while DONE must not disturb the held product
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        check("t5_done_overrun", PW'(overrun),    64'h1);
        check("t5_done_prod",    prod_out,        64'h8000_0000_0000_0000);
        check("t5_done_valid",   PW'(prod_valid), 64'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        cyc();

        // 6: reset mid-collection
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(PW'($urandom) | (PW'($urandom) << 32), 0, 40);
        rst_n = 1'b0;
        #1;
        check("t6_prod",    prod_out,        64'h0);
        check("t6_valid",   PW'(prod_valid), 64'h0);
        check("t6_busy",    PW'(busy),       64'h0);
        check("t6_overrun", PW'(overrun),    64'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        send_word(64'hFFFF_FFFF_FFFF_FFFF, 0, PW + 4);
        check("t6_post_overrun", PW'(overrun),    64'h1);
        check("t6_post_valid",   PW'(prod_valid), 64'h0);

        // Random traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 2) == 0));
        end
        idle();
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
